ram_access_sequencer: RTL and testbench

//  Sequences the synchronous RAM's multi-cycle sysbus protocol (load_MAR, load_MDR, CS, R_NW, MDR_bus).

---
 rtl/ram_seq_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 22 ++
 rtl/ram_access_sequencer.sv | 134 +++++++++++++
 tb/tb_ram_access_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_seq_pkg.sv
// Shared types and helpers for the RAM access sequencer.
package ram_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        DATA   = 3'd2,
        ACCESS = 3'd3,
        READ   = 3'd4,
        DONE   = 3'd5
    } seq_state_t;

    // The address field is whatever is left of a sysbus word after the opcode.
    function automatic int addr_w(input int word_w, input int op_w);
        return word_w - op_w;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins outright, a tie goes
// to whichever requester was not granted last time.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    // Pick the winner purely from the current request pattern and history bit.
    always_comb begin
        valid = |req;
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram_access_sequencer.sv
// Sequences the RAM's multi-cycle sysbus protocol for two requesters.
// Every transaction starts from IDLE, is fully latched at grant time and ends
// with a single-cycle done pulse on the granted requester's bit.
module ram_access_sequencer
    import ram_seq_pkg::*;
#(
    parameter  int WORD_W = 8,
    parameter  int OP_W   = 3,
    localparam int AW     = addr_w(WORD_W, OP_W)
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [AW-1:0]     addr0,
    input  logic [AW-1:0]     addr1,
    input  logic [WORD_W-1:0] wdata0,
    input  logic [WORD_W-1:0] wdata1,
    output logic [1:0]        done,
    output logic [WORD_W-1:0] rdata,
    output logic              busy,
    output logic              load_MAR,
    output logic              load_MDR,
    output logic              CS,
    output logic              R_NW,
    output logic              MDR_bus,
    output logic [WORD_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [WORD_W-1:0] bus_in
);

    seq_state_t        state;
    seq_state_t        state_next;
    logic              arb_grant;
    logic              arb_valid;
    logic              take_grant;
    logic              grant_q;
    logic              last_grant;
    logic [AW-1:0]     cur_addr;
    logic              cur_we;
    logic [WORD_W-1:0] cur_wdata;

    rr_arbiter2 u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    // Requests are only honoured while idle; everything else waits.
    assign take_grant = (state == IDLE) && arb_valid;

    // Control state: sequencer state, grant history and the read result.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            rdata      <= '0;
        end else begin
            state <= state_next;
            if (take_grant) begin
                last_grant <= arb_grant;
                grant_q    <= arb_grant;
            end
            if (state == READ) begin
                rdata <= bus_in;
            end
        end
    end

    // Transaction operands are captured at grant so requesters may move on.
    always_ff @(posedge clock) begin
        if (take_grant) begin
            cur_addr  <= arb_grant ? addr1  : addr0;
            cur_we    <= we[arb_grant];
            cur_wdata <= arb_grant ? wdata1 : wdata0;
        end
    end

    // Next-state logic and Moore decode of the RAM control strobes.
    always_comb begin
        state_next = state;
        done       = 2'b00;
        busy       = 1'b1;
        load_MAR   = 1'b0;
        load_MDR   = 1'b0;
        CS         = 1'b0;
        R_NW       = 1'b0;
        MDR_bus    = 1'b0;
        bus_out    = '0;
        bus_oe     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (arb_valid) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                bus_oe     = 1'b1;
                bus_out    = {{OP_W{1'b0}}, cur_addr};
                load_MAR   = 1'b1;
                state_next = cur_we ? DATA : ACCESS;
            end
            DATA: begin
                bus_oe     = 1'b1;
                bus_out    = cur_wdata;
                load_MDR   = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                // The memory array is only written here, so a reset in any
                // earlier state leaves the RAM contents untouched.
                CS         = 1'b1;
                R_NW       = ~cur_we;
                state_next = cur_we ? DONE : READ;
            end
            READ: begin
                MDR_bus    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done[grant_q] = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Bench for ram_access_sequencer: a behavioural sysbus RAM plus a
// transaction-level reference model (grant history and memory image).
module tb_ram_access_sequencer;

    logic        clock;
    logic        n_reset;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [4:0]  addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic [1:0]  done;
    logic [7:0]  rdata;
    logic        busy;
    logic        load_MAR, load_MDR, CS, R_NW, MDR_bus;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic [7:0]  bus_in;

    int checks = 0;
    int errors = 0;

    // Sysbus RAM environment
    logic [7:0] ram [32];
    logic [4:0] mar;
    logic [7:0] mdr;
    logic [7:0] sysbus;

    // Reference model state
    logic [7:0] ref_mem [32];
    logic       ref_last;

    ram_access_sequencer #(.WORD_W(8), .OP_W(3)) dut (
        .clock    (clock),
        .n_reset  (n_reset),
        .req      (req),
        .we       (we),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .done     (done),
        .rdata    (rdata),
        .busy     (busy),
        .load_MAR (load_MAR),
        .load_MDR (load_MDR),
        .CS       (CS),
        .R_NW     (R_NW),
        .MDR_bus  (MDR_bus),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .bus_in   (bus_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign sysbus = bus_oe ? bus_out : (MDR_bus ? mdr : 8'h00);
    assign bus_in = sysbus;

    always @(posedge clock) begin
        if (load_MAR) mar <= sysbus[4:0];
        if (load_MDR) mdr <= sysbus;
        if (CS) begin
            if (R_NW) mdr <= ram[mar];
            else      ram[mar] <= mdr;
        end
    end

    // Bus exclusivity and strobe one-hotness, every cycle out of reset
    always @(negedge clock) begin
        if (n_reset) begin
            checks++;
            assert (!(bus_oe && MDR_bus) && $onehot0({load_MAR, load_MDR, CS, MDR_bus}))
            else begin
                errors++;
                $error("FAIL bus_exclusive observed oe=%b mdr_bus=%b strobes=%b", bus_oe, MDR_bus,
                       {load_MAR, load_MDR, CS, MDR_bus});
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction: drive, check each protocol phase, check done/rdata.
    task automatic txn(input logic [1:0] rq, input logic [1:0] w,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input int drop_cyc, input bit hold, input string tag);
        logic       g;
        logic [4:0] ea;
        logic [7:0] ed;
        logic       ew;
        int         cyc;
        if (rq == 2'b01)      g = 1'b0;
        else if (rq == 2'b10) g = 1'b1;
        else                  g = ~ref_last;
        ref_last = g;
        ea = g ? a1 : a0;
        ed = g ? d1 : d0;
        ew = w[g];
        @(negedge clock);
        req = rq; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        cyc = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock); #1;
            cyc = c;
            if (c == 1) begin
                chk({tag, "_addr"}, {busy, load_MAR, bus_oe, bus_out}, {1'b1, 1'b1, 1'b1, 3'b000, ea});
                we = ~w; addr0 = ~a0; addr1 = ~a1; wdata0 = ~d0; wdata1 = ~d1;
            end else if (c == 2) begin
                if (ew) chk({tag, "_data"}, {load_MDR, bus_oe, bus_out}, {1'b1, 1'b1, ed});
                else    chk({tag, "_rd_access"}, {CS, R_NW, bus_oe}, 3'b110);
            end else if (c == 3) begin
                if (ew) chk({tag, "_wr_access"}, {CS, R_NW, bus_oe}, 3'b100);
                else    chk({tag, "_rd_bus"}, {MDR_bus, bus_oe}, 2'b10);
            end
            if (c == drop_cyc) req = 2'b00;
            if (done !== 2'b00) break;
        end
        chk({tag, "_latency"}, cyc, 4);
        chk({tag, "_done"}, done, g ? 2'b10 : 2'b01);
        if (ew) ref_mem[ea] = ed;
        else    chk({tag, "_rdata"}, rdata, ref_mem[ea]);
        if (!hold) req = 2'b00;
        @(posedge clock); #1;
        chk({tag, "_done_once"}, {done, busy}, 3'b000);
        if (!ew) chk({tag, "_rdata_hold"}, rdata, ref_mem[ea]);
    endtask

    task automatic reset_pulse();
        @(negedge clock);
        n_reset = 1'b0;
        #2;
        n_reset = 1'b1;
        ref_last = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rq;
        logic [1:0] w;
        for (int i = 0; i < 32; i++) begin
            ram[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        mar = '0; mdr = '0;
        req = 2'b00; we = 2'b00; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        ref_last = 1'b1;
        n_reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs", {done, busy, load_MAR, load_MDR, CS, R_NW, MDR_bus, bus_oe, bus_out, rdata},
            '0);
        @(negedge clock);
        n_reset = 1'b1;

        // 1: write 5'h1C = 8'hA5 from requester 0
        txn(2'b01, 2'b01, 5'h1C, 5'h00, 8'hA5, 8'h00, 0, 1'b0, "t1_write");
        chk("t1_ram", ram[5'h1C], 8'hA5);

        // 2: read it back
        txn(2'b01, 2'b00, 5'h1C, 5'h00, 8'h00, 8'h00, 0, 1'b0, "t2_read");

        // 3: contention held across three transactions, fresh history
        reset_pulse();
        txn(2'b11, 2'b00, 5'h1C, 5'h02, 8'h00, 8'h00, 0, 1'b1, "t3_a");
        txn(2'b11, 2'b11, 5'h03, 5'h04, 8'h11, 8'h22, 0, 1'b1, "t3_b");
        txn(2'b11, 2'b00, 5'h04, 5'h05, 8'h00, 8'h00, 0, 1'b0, "t3_c");

        // 4: requester 1 writes, drops req while in DATA
        txn(2'b10, 2'b10, 5'h00, 5'h1D, 8'h00, 8'h3C, 2, 1'b0, "t4_drop");
        chk("t4_ram", ram[5'h1D], 8'h3C);

        // 5: reset during ACCESS of a write must not reach the array
        @(negedge clock);
        req = 2'b01; we = 2'b01; addr0 = 5'h1D; wdata0 = 8'hFF;
        @(posedge clock); #1;
        req = 2'b00;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("t5_in_access", {CS, R_NW}, 2'b10);
        #2;
        n_reset = 1'b0;
        #1;
        chk("t5_reset_outputs", {done, busy, load_MAR, load_MDR, CS, R_NW, MDR_bus, bus_oe, bus_out, rdata},
            '0);
        #2;
        n_reset = 1'b1;
        ref_last = 1'b1;
        @(posedge clock); #1;
        chk("t5_ram_kept", ram[5'h1D], 8'h3C);
        txn(2'b01, 2'b00, 5'h1D, 5'h00, 8'h00, 8'h00, 0, 1'b0, "t5_readback");

        // Randomised traffic against the reference model
        for (int i = 0; i < 24; i++) begin
            rq = 2'($urandom_range(1, 3));
            w  = 2'($urandom);
            txn(rq, w, 5'($urandom), 5'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom), "rand");
        end
        @(negedge clock);
        req = 2'b00;
        repeat (8) @(posedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
